// File: rtl/data_bus_pkg.sv
// Shared sizing helpers for the data-bus arbiter and its ID FIFO.
package data_bus_pkg;

  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int calc_id_w(input int num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

  function automatic int calc_occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/data_bus_id_fifo.sv
// In-order FIFO of master indices for granted-but-unanswered transactions.
module data_bus_id_fifo
  import data_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  localparam int CNT_W = calc_occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds only payload; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// N-master to 1-slave round-robin arbiter for the req/gnt/rvalid data bus.
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int BE_W  = calc_be_w(DATA_W),
  localparam int OCC_W = calc_occ_w(MAX_OUTSTANDING)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_be,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_we,
  output logic [BE_W-1:0]               s_be,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_gnt,
  input  logic                          s_rvalid,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [OCC_W-1:0]              outstanding,
  output logic                          resp_err
);
  localparam int ID_W = calc_id_w(NUM_MASTERS);

  logic [ID_W-1:0] sel, rr_q, rr_d, lock_idx_q, lock_idx_d, fifo_head;
  logic            sel_req, hs, lock_q, lock_d, fifo_full, fifo_empty;

  function automatic logic [NUM_MASTERS-1:0] idx_onehot(input logic [ID_W-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ID_W'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Locked index wins; otherwise scan downward so the nearest requester at/after rr_q is kept.
  always_comb begin
    sel     = '0;
    sel_req = 1'b0;
    if (lock_q) begin
      sel     = lock_idx_q;
      sel_req = |(m_req & idx_onehot(lock_idx_q));
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        if (m_req[(int'(rr_q) + k) % NUM_MASTERS]) begin
          sel     = ID_W'((int'(rr_q) + k) % NUM_MASTERS);
          sel_req = 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_we    = 1'b0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel_req && (ID_W'(i) == sel)) begin
        s_we    = m_we[i];
        s_be    = m_be[i*BE_W +: BE_W];
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Gating on full (not on the pop) keeps s_rvalid out of the s_req cone.
  assign s_req    = sel_req & ~fifo_full & ~rst;
  assign hs       = s_req & s_gnt;
  assign m_gnt    = hs ? idx_onehot(sel) : '0;
  assign m_rvalid = (s_rvalid & ~fifo_empty & ~rst) ? idx_onehot(fifo_head) : '0;
  assign m_rdata  = s_rdata;
  assign resp_err = s_rvalid & fifo_empty & ~rst;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    if (hs) begin
      lock_d = 1'b0;
      rr_d   = (sel == ID_W'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
    end else if (s_req) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

  data_bus_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .pop   (s_rvalid & ~rst),
    .wdata (sel),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench with response scoreboards for a 2-master/32-bit and a 4-master/64-bit arbiter.
module tb_data_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]   a_m_req, a_m_we, a_m_gnt, a_m_rvalid;
  logic [7:0]   a_m_be;
  logic [63:0]  a_m_addr, a_m_wdata;
  logic [31:0]  a_m_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic         a_s_req, a_s_we, a_s_gnt, a_s_rvalid, a_resp_err;
  logic [3:0]   a_s_be;
  logic [1:0]   a_outstanding;

  logic [3:0]   b_m_req, b_m_we, b_m_gnt, b_m_rvalid;
  logic [31:0]  b_m_be, b_s_addr;
  logic [127:0] b_m_addr;
  logic [255:0] b_m_wdata;
  logic [63:0]  b_m_rdata, b_s_wdata, b_s_rdata;
  logic         b_s_req, b_s_we, b_s_gnt, b_s_rvalid, b_resp_err;
  logic [7:0]   b_s_be;
  logic [1:0]   b_outstanding;

  data_bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)) u_dut_a (
    .clk(clk), .rst(rst), .m_req(a_m_req), .m_we(a_m_we), .m_be(a_m_be), .m_addr(a_m_addr),
    .m_wdata(a_m_wdata), .m_gnt(a_m_gnt), .m_rvalid(a_m_rvalid), .m_rdata(a_m_rdata),
    .s_req(a_s_req), .s_we(a_s_we), .s_be(a_s_be), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_gnt(a_s_gnt), .s_rvalid(a_s_rvalid), .s_rdata(a_s_rdata),
    .outstanding(a_outstanding), .resp_err(a_resp_err)
  );

  data_bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(64), .MAX_OUTSTANDING(2)) u_dut_b (
    .clk(clk), .rst(rst), .m_req(b_m_req), .m_we(b_m_we), .m_be(b_m_be), .m_addr(b_m_addr),
    .m_wdata(b_m_wdata), .m_gnt(b_m_gnt), .m_rvalid(b_m_rvalid), .m_rdata(b_m_rdata),
    .s_req(b_s_req), .s_we(b_s_we), .s_be(b_s_be), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_gnt(b_s_gnt), .s_rvalid(b_s_rvalid), .s_rdata(b_s_rdata),
    .outstanding(b_outstanding), .resp_err(b_resp_err)
  );

  typedef struct {
    int          idx;
    logic [63:0] data;
  } resp_t;

  resp_t a_q[$];
  resp_t b_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Response monitors: every routed response is matched against the next expected one.
  always @(negedge clk) begin
    if (a_m_rvalid != 2'b00) begin
      resp_t e;
      if (a_q.size() == 0) begin
        chk("a_unexpected_rvalid", 64'(a_m_rvalid), 64'd0);
      end else begin
        e = a_q.pop_front();
        chk("a_rvalid_route", 64'(a_m_rvalid), 64'd1 << e.idx);
        chk("a_rdata", 64'(a_m_rdata), e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (b_m_rvalid != 4'b0000) begin
      resp_t e;
      if (b_q.size() == 0) begin
        chk("b_unexpected_rvalid", 64'(b_m_rvalid), 64'd0);
      end else begin
        e = b_q.pop_front();
        chk("b_rvalid_route", 64'(b_m_rvalid), 64'd1 << e.idx);
        chk("b_rdata", b_m_rdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  alt_gnt [4];
    logic [31:0] alt_dat [4];
    alt_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    alt_dat = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

    rst = 1'b1;
    a_m_req = 2'b01; a_m_we = '0; a_m_be = '0; a_m_addr = '0; a_m_wdata = '0;
    a_s_gnt = 1'b1; a_s_rvalid = 1'b1; a_s_rdata = '0;
    b_m_req = '0; b_m_we = '0; b_m_be = '0; b_m_addr = '0; b_m_wdata = '0;
    b_s_gnt = 1'b0; b_s_rvalid = 1'b0; b_s_rdata = '0;

    // Reset state, with live inputs that must be masked
    samp();
    chk("rst_m_gnt", 64'(a_m_gnt), 64'd0);
    chk("rst_s_req", 64'(a_s_req), 64'd0);
    chk("rst_m_rvalid", 64'(a_m_rvalid), 64'd0);
    chk("rst_resp_err", 64'(a_resp_err), 64'd0);
    chk("rst_outstanding", 64'(a_outstanding), 64'd0);
    chk("rst_b_s_req", 64'(b_s_req), 64'd0);

    // Single read from master 0
    step();
    rst = 1'b0; a_s_rvalid = 1'b0;
    a_m_req = 2'b01; a_m_be = 8'h0F; a_m_addr[31:0] = 32'h0000_1000;
    samp();
    chk("t1_gnt", 64'(a_m_gnt), 64'h1);
    chk("t1_s_addr", 64'(a_s_addr), 64'h1000);
    chk("t1_s_be", 64'(a_s_be), 64'hF);
    chk("t1_out0", 64'(a_outstanding), 64'd0);
    a_q.push_back('{0, 64'hDEAD_BEEF});
    step();
    a_m_req = 2'b00; a_s_gnt = 1'b0; a_s_rvalid = 1'b1; a_s_rdata = 32'hDEAD_BEEF;
    samp();
    chk("t1_out1", 64'(a_outstanding), 64'd1);
    chk("t1_gnt_after", 64'(a_m_gnt), 64'd0);
    step();
    a_s_rvalid = 1'b0;
    samp();
    chk("t1_out_final", 64'(a_outstanding), 64'd0);

    // Two continuous requesters alternate after a fresh reset (rr pointer back to 0)
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_m_req = 2'b11; a_m_we = 2'b10; a_s_gnt = 1'b1;
    a_m_addr = {32'h0000_3000, 32'h0000_2000};
    for (int k = 0; k < 4; k++) begin
      a_s_rvalid = (k > 0);
      a_s_rdata  = (k > 0) ? alt_dat[k-1] : 32'h0;
      samp();
      chk("t2_gnt", 64'(a_m_gnt), 64'(alt_gnt[k]));
      chk("t2_s_addr", 64'(a_s_addr), (alt_gnt[k] == 2'b01) ? 64'h2000 : 64'h3000);
      chk("t2_s_we", 64'(a_s_we), (alt_gnt[k] == 2'b01) ? 64'd0 : 64'd1);
      a_q.push_back('{(alt_gnt[k] == 2'b01) ? 0 : 1, 64'(alt_dat[k])});
      step();
    end
    a_m_req = 2'b00; a_m_we = 2'b00; a_s_gnt = 1'b0; a_s_rvalid = 1'b1; a_s_rdata = alt_dat[3];
    step();
    a_s_rvalid = 1'b0;
    samp();
    chk("t2_out_final", 64'(a_outstanding), 64'd0);

    // Slave stall: master 1 stays selected while master 0 joins
    step();
    a_m_req = 2'b10; a_m_addr = {32'h0000_4000, 32'h0000_5000}; a_s_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) a_m_req = 2'b11;
      samp();
      chk("t3_stall_s_req", 64'(a_s_req), 64'd1);
      chk("t3_stall_s_addr", 64'(a_s_addr), 64'h4000);
      chk("t3_stall_gnt", 64'(a_m_gnt), 64'd0);
      step();
    end
    a_s_gnt = 1'b1;
    samp();
    chk("t3_first_gnt", 64'(a_m_gnt), 64'h2);
    a_q.push_back('{1, 64'hAAAA_0004});
    step();
    a_m_req = 2'b01; a_s_rvalid = 1'b1; a_s_rdata = 32'hAAAA_0004;
    samp();
    chk("t3_second_gnt", 64'(a_m_gnt), 64'h1);
    chk("t3_second_addr", 64'(a_s_addr), 64'h5000);
    a_q.push_back('{0, 64'hAAAA_0005});
    step();
    a_m_req = 2'b00; a_s_gnt = 1'b0; a_s_rdata = 32'hAAAA_0005;
    step();
    a_s_rvalid = 1'b0;
    samp();
    chk("t3_out_final", 64'(a_outstanding), 64'd0);

    // FIFO full: third request waits, with one bubble on the popping cycle
    step();
    a_m_req = 2'b11; a_s_gnt = 1'b1; a_m_addr = {32'h0000_6800, 32'h0000_6000};
    samp();
    chk("t4_gnt0", 64'(a_m_gnt), 64'h2);
    a_q.push_back('{1, 64'hBBBB_0006});
    step();
    a_m_req = 2'b01;
    samp();
    chk("t4_gnt1", 64'(a_m_gnt), 64'h1);
    a_q.push_back('{0, 64'hBBBB_0007});
    step();
    a_m_addr[31:0] = 32'h0000_7000;
    samp();
    chk("t4_full_s_req", 64'(a_s_req), 64'd0);
    chk("t4_full_out", 64'(a_outstanding), 64'd2);
    step();
    a_s_rvalid = 1'b1; a_s_rdata = 32'hBBBB_0006;
    samp();
    chk("t4_bubble_s_req", 64'(a_s_req), 64'd0);
    chk("t4_bubble_gnt", 64'(a_m_gnt), 64'd0);
    step();
    a_s_rvalid = 1'b0;
    samp();
    chk("t4_out_after_pop", 64'(a_outstanding), 64'd1);
    chk("t4_third_gnt", 64'(a_m_gnt), 64'h1);
    chk("t4_third_addr", 64'(a_s_addr), 64'h7000);
    a_q.push_back('{0, 64'hBBBB_0008});
    step();
    a_m_req = 2'b00; a_s_gnt = 1'b0; a_s_rvalid = 1'b1; a_s_rdata = 32'hBBBB_0007;
    step();
    a_s_rdata = 32'hBBBB_0008;
    step();
    a_s_rvalid = 1'b0;
    samp();
    chk("t4_out_final", 64'(a_outstanding), 64'd0);

    // Stray responses: empty FIFO, push+pop on empty, and a late response after reset
    step();
    a_s_rvalid = 1'b1; a_s_rdata = 32'hCCCC_0000;
    samp();
    chk("t5_empty_err", 64'(a_resp_err), 64'd1);
    chk("t5_empty_rvalid", 64'(a_m_rvalid), 64'd0);
    step();
    a_s_rvalid = 1'b0;
    samp();
    chk("t5_err_clear", 64'(a_resp_err), 64'd0);
    step();
    a_m_req = 2'b01; a_s_gnt = 1'b1; a_s_rvalid = 1'b1;
    samp();
    chk("t5_pushpop_gnt", 64'(a_m_gnt), 64'h1);
    chk("t5_pushpop_err", 64'(a_resp_err), 64'd1);
    chk("t5_pushpop_rvalid", 64'(a_m_rvalid), 64'd0);
    step();
    a_m_req = 2'b00; a_s_gnt = 1'b0; a_s_rvalid = 1'b0;
    samp();
    chk("t5_out_pending", 64'(a_outstanding), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; a_s_rvalid = 1'b1; a_s_rdata = 32'hCCCC_0001;
    samp();
    chk("t5_late_err", 64'(a_resp_err), 64'd1);
    chk("t5_late_rvalid", 64'(a_m_rvalid), 64'd0);
    chk("t5_late_out", 64'(a_outstanding), 64'd0);
    step();
    a_s_rvalid = 1'b0;
    samp();
    chk("t5_out_final", 64'(a_outstanding), 64'd0);

    // Four masters, 64-bit data: move rr to 2, then masters 1 and 3 compete
    step();
    b_m_be   = {8'hF0, 8'h3C, 8'h0F, 8'hAA};
    b_m_addr = {32'h0000_B300, 32'h0000_B200, 32'h0000_B100, 32'h0000_B000};
    b_m_req  = 4'b0010; b_s_gnt = 1'b1;
    samp();
    chk("t6_warm_gnt", 64'(b_m_gnt), 64'h2);
    b_q.push_back('{1, 64'h0123_4567_89AB_CDEF});
    step();
    b_m_req = 4'b1010; b_s_rvalid = 1'b1; b_s_rdata = 64'h0123_4567_89AB_CDEF;
    samp();
    chk("t6_gnt_m3", 64'(b_m_gnt), 64'h8);
    chk("t6_be_m3", 64'(b_s_be), 64'hF0);
    chk("t6_addr_m3", 64'(b_s_addr), 64'hB300);
    b_q.push_back('{3, 64'hFEDC_BA98_7654_3210});
    step();
    b_m_req = 4'b0010; b_s_rdata = 64'hFEDC_BA98_7654_3210;
    samp();
    chk("t6_gnt_m1", 64'(b_m_gnt), 64'h2);
    chk("t6_be_m1", 64'(b_s_be), 64'h0F);
    b_q.push_back('{1, 64'h5555_6666_7777_8888});
    step();
    b_m_req = 4'b0000; b_s_gnt = 1'b0; b_s_rdata = 64'h5555_6666_7777_8888;
    step();
    b_s_rvalid = 1'b0;
    samp();
    chk("t6_out_final", 64'(b_outstanding), 64'd0);

    step();
    chk("a_queue_drained", 64'(a_q.size()), 64'd0);
    chk("b_queue_drained", 64'(b_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the core's req/gnt/rvalid data bus.
- Lets instruction fetch, LSU, debug and DMA masters share one memory or peripheral slave.
- Round-robin arbitration; the selected request stays stable until the slave grants it.
- Tracks up to MAX_OUTSTANDING granted transactions in an in-order ID FIFO, and routes each slave response to the master that issued the request.

Parameters:
- NUM_MASTERS, 2, number of master ports (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); BE_W = DATA_W/8
- MAX_OUTSTANDING, 2, ID FIFO depth (≥1); max granted-but-unanswered transactions

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_req  in  NUM_MASTERS  per-master request
- m_we  in  NUM_MASTERS  per-master write enable
- m_be  in  NUM_MASTERS*BE_W  packed byte enables, master i at [i*BE_W +: BE_W]
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data
- m_gnt  out  NUM_MASTERS  per-master grant
- m_rvalid  out  NUM_MASTERS  per-master response valid
- m_rdata  out  DATA_W  shared read data, qualified by m_rvalid
- s_req  out  1  slave request
- s_we  out  1  slave write enable
- s_be  out  BE_W  slave byte enables
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_gnt  in  1  slave grant
- s_rvalid  in  1  slave response valid
- s_rdata  in  DATA_W  slave read data
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy
- resp_err  out  1  one-cycle pulse: s_rvalid arrived with no outstanding transaction

Behaviour:
- Bus protocol:
  - A master holds req/we/be/addr/wdata stable until its gnt.
  - A handshake is s_req & s_gnt in the same cycle.
  - Every handshake (read or write) produces exactly one s_rvalid in a later cycle (≥1 cycle), in order.
- Reset: FIFO empty, outstanding=0, rr pointer=0, lock clear. All m_gnt, m_rvalid, s_req and resp_err read 0 in the reset cycle.
- Selection:
  - If the lock is set, the locked master index is selected.
  - Otherwise, the first requesting master at or after the rr pointer, wrapping modulo NUM_MASTERS.
  - Selection is combinational from m_req and state.
- Forwarding:
  - s_req = selected m_req & ~fifo_full.
  - s_we/s_be/s_addr/s_wdata are muxed from the selected master (zeros when no request).
  - m_gnt[sel] = s_gnt & s_req. All other m_gnt are 0. There is a combinational path s_gnt→m_gnt.
- Lock:
  - Set when s_req=1 and s_gnt=0; stores the selected index.
  - Cleared on the handshake.
  - Prevents switching the slave-facing request while the slave stalls.
- RR pointer: on handshake, pointer ← (winner+1) mod NUM_MASTERS. Unchanged otherwise.
- ID FIFO:
  - The handshake pushes the winner index.
  - s_rvalid pops the head.
  - m_rvalid[head] = s_rvalid & ~fifo_empty, with zero-cycle latency. m_rdata = s_rdata.
- Full FIFO: s_req is held 0 even if a pop occurs in the same cycle. This deliberately avoids an s_rvalid→s_req path and costs one bubble.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged, pointers both advance.
- Simultaneous push and pop on an empty FIFO: the push is performed; the pop raises resp_err and no m_rvalid.
- s_rvalid while the FIFO is empty: resp_err=1 for that cycle, all m_rvalid=0, state unchanged.
- Reset mid-transaction: pending IDs are discarded. Late slave responses after reset raise resp_err and are not routed.
- NUM_MASTERS=1: ID width is 1 bit, index always 0, arbitration is trivial.

Decomposition:
- Package data_bus_pkg:
  - localparam functions for BE_W and ID_W = (NUM_MASTERS>1) ? $clog2(NUM_MASTERS) : 1.
  - Occupancy width helper.
- Sub-module data_bus_id_fifo (parametrised DEPTH, WIDTH):
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Synchronous active-high reset.
  - Circular buffer with wrap-around read/write pointers.
- Arbiter top contains the selection, lock and rr logic.

Test Plan:
- Single master 0, slave gnt immediate, rvalid 1 cycle later, rdata 0xDEADBEEF → m_gnt[0] in cycle 0; m_rvalid[0] with m_rdata=0xDEADBEEF in cycle 1; outstanding 1 then 0.
- Masters 0 and 1 request continuously, slave always grants → grants alternate 0,1,0,1; responses routed to matching m_rvalid bit in issue order.
- Master 1 requests with s_gnt low for 3 cycles while master 0 raises req in cycle 1 → s_addr stays at master 1's address for all 3 stall cycles; master 1 is granted first, master 0 next.
- MAX_OUTSTANDING=2, three back-to-back requests, no rvalid → two grants then s_req=0, outstanding=2. One rvalid → third request is granted the following cycle.
- s_rvalid pulse with empty FIFO, then rst asserted with 1 outstanding followed by a late s_rvalid → resp_err=1 in both cases; no m_rvalid; outstanding=0.
- NUM_MASTERS=4, DATA_W=64, masters 1 and 3 requesting, rr pointer=2 → master 3 granted first, then master 1; s_be is 8 bits wide and matches the granted master.
